pc_sequencer: RTL

- Multi-cycle fetch/execute controller for the JZJCoreF datapath.
- Owns the architectural PC register and sequences instruction fetch.
- Holds the fetched instruction stable while the branch ALU and the rest of the datapath evaluate it.
- Commits the next PC taken from the branch ALU's programCounterInput, and halts the core on datapath error flags or fetch timeout.

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute controller for the JZJCoreF datapath.
// Owns the architectural PC and sequences fetch and execute.
// It latches each fetched instruction and holds it while the datapath evaluates it.
// It commits the next PC from the branch ALU.
// It halts on datapath error flags, on fetch timeout or on an external halt request.
// Optional build macro: PC_SEQUENCER_MISALIGN_TRAP_EN. When it is defined, the core
// halts with cause 5 on a branch/jump target that is not word-aligned.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR  = 32'h00000000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   output logic        fetchRequest,
   output logic [31:0] fetchAddress,
   input  logic        fetchValid,
   input  logic [31:0] fetchData,
   output logic [31:0] instruction,
   output logic [31:0] pcOfInstruction,
   input  logic [31:0] programCounterInput,
   input  logic        branchALUBadFunct3,
   input  logic        decodeBadInstruction,
   input  logic        stallExecute,
   input  logic        haltRequest,
   output logic        executeEnable,
   output logic        halted,
   output logic [2:0]  haltCause
);

   typedef enum logic [1:0] {BOOT, FETCH, EXECUTE, HALTED} stateType;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;
   localparam int COUNT_WIDTH = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   // Value of the counter in the last request cycle that is allowed before the timeout.
   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(FETCH_TIMEOUT - 1);

   localparam logic [2:0] CAUSE_BAD_FUNCT3  = 3'd1;
   localparam logic [2:0] CAUSE_ILLEGAL     = 3'd2;
   localparam logic [2:0] CAUSE_TIMEOUT     = 3'd3;
   localparam logic [2:0] CAUSE_EXTERNAL    = 3'd4;
   localparam logic [2:0] CAUSE_MISALIGNED  = 3'd5;

   stateType               stateReg;
   logic [31:0]            pcReg;
   logic [31:0]            instructionReg;
   logic [COUNT_WIDTH-1:0] timeoutCount;
   logic [2:0]             haltCauseReg;

   logic misalignTarget;
   logic timeoutHit;
   logic commitReady;

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
   assign misalignTarget = (programCounterInput[1:0] != 2'b00);
`else
   assign misalignTarget = 1'b0;
`endif

   // A timeout value of zero disables the check entirely.
   assign timeoutHit = (FETCH_TIMEOUT != 0) && (timeoutCount == COUNT_LAST);

   // The commit strobe is the only output that depends on inputs.
   // It fires in the single EXECUTE cycle in which nothing blocks the instruction.
   assign commitReady = (stateReg == EXECUTE) && !branchALUBadFunct3 &&
                        !decodeBadInstruction && !misalignTarget && !stallExecute;

   assign executeEnable   = commitReady;
   assign fetchRequest    = (stateReg == FETCH);
   assign fetchAddress    = pcReg;
   assign pcOfInstruction = pcReg;
   assign instruction     = instructionReg;
   assign halted          = (stateReg == HALTED);
   assign haltCause       = haltCauseReg;

   // Sequencer state, PC, instruction latch, fetch timeout counter and halt cause.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg       <= BOOT;
         pcReg          <= RESET_VECTOR;
         instructionReg <= NOP_INSTRUCTION;
         timeoutCount   <= '0;
         haltCauseReg   <= 3'd0;
      end else begin
         case (stateReg)
            BOOT: begin
               stateReg <= FETCH;
            end
            FETCH: begin
               // Returning data beats both the halt request and the timeout.
               if (fetchValid) begin
                  instructionReg <= fetchData;
                  timeoutCount   <= '0;
                  stateReg       <= EXECUTE;
               end else if (haltRequest) begin
                  stateReg     <= HALTED;
                  haltCauseReg <= CAUSE_EXTERNAL;
               end else if (timeoutHit) begin
                  stateReg     <= HALTED;
                  haltCauseReg <= CAUSE_TIMEOUT;
               end else begin
                  timeoutCount <= timeoutCount + COUNT_WIDTH'(1);
               end
            end
            EXECUTE: begin
               if (branchALUBadFunct3) begin
                  stateReg     <= HALTED;
                  haltCauseReg <= CAUSE_BAD_FUNCT3;
               end else if (decodeBadInstruction) begin
                  stateReg     <= HALTED;
                  haltCauseReg <= CAUSE_ILLEGAL;
               end else if (misalignTarget) begin
                  stateReg     <= HALTED;
                  haltCauseReg <= CAUSE_MISALIGNED;
               end else if (!stallExecute) begin
                  // The instruction commits even when an external halt lands on this cycle.
                  pcReg <= programCounterInput;
                  if (haltRequest) begin
                     stateReg     <= HALTED;
                     haltCauseReg <= CAUSE_EXTERNAL;
                  end else begin
                     stateReg <= FETCH;
                  end
               end
            end
            HALTED: begin
               stateReg <= HALTED;
            end
            default: begin
               stateReg <= BOOT;
            end
         endcase
      end
   end

endmodule
